// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: one-cold column strobe, 2-flop row sync, whole-matrix debounce, lowest-index key select.
// key_valid/key_code/key_held register one cycle after the scan completing on the c3 dwell; no backpressure, pulses are dropped if unobserved.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int              DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      ACCEPT_CNT = 4'(DEBOUNCE_SCANS - 1);

  logic [DW-1:0] dwell_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_s1, row_s2;
  logic [15:0]   snap, prev_snap, debounced;
  logic [3:0]    stable_cnt;

  logic          dwell_last, scan_done, match, accept, pulse;
  logic [15:0]   snap_next;
  logic [3:0]    cnt_next, new_key, old_key;

  function automatic logic [3:0] first_key(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Index is 4*column + row; row 0 is the top of the keypad.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h4;
      4'd2:    code = 4'h7;
      4'd3:    code = 4'h0;
      4'd4:    code = 4'h2;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h8;
      4'd7:    code = 4'hF;
      4'd8:    code = 4'h3;
      4'd9:    code = 4'h6;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hE;
      4'd12:   code = 4'hA;
      4'd13:   code = 4'hB;
      4'd14:   code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign col = ~(4'b1000 >> col_idx);

  always_comb begin
    dwell_last = (dwell_cnt == DWELL_LAST);
    scan_done  = dwell_last && (col_idx == 2'd3);
    snap_next  = snap;
    snap_next[{col_idx, 2'b00} +: 4] = ~row_s2;
    match      = (snap_next == prev_snap);
    cnt_next   = 4'd0;
    if (match) cnt_next = (stable_cnt == 4'hF) ? 4'hF : stable_cnt + 4'd1;
    // cnt_next counts matches against the previous scan, so N identical scans give N-1.
    accept     = scan_done && (cnt_next >= ACCEPT_CNT);
    new_key    = first_key(snap_next);
    old_key    = first_key(debounced);
    pulse      = accept && (|snap_next) && (~|debounced || (new_key != old_key));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_cnt  <= '0;
      col_idx    <= 2'd0;
      row_s1     <= 4'hF;
      row_s2     <= 4'hF;
      snap       <= '0;
      prev_snap  <= '0;
      debounced  <= '0;
      stable_cnt <= 4'd0;
      key_code   <= 4'd0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      row_s1    <= row;
      row_s2    <= row_s1;
      key_valid <= pulse;
      if (dwell_last) begin
        dwell_cnt <= '0;
        col_idx   <= col_idx + 2'd1;
        snap      <= snap_next;
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
      if (scan_done) begin
        prev_snap  <= snap_next;
        stable_cnt <= cnt_next;
      end
      if (accept) begin
        debounced <= snap_next;
        key_held  <= |snap_next;
      end
      if (pulse) key_code <= key_map(new_key);
    end
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix scanner for the 4x4 keypad that controls player B. It drives the column strobes on the keypad connector, samples the row returns, debounces whole-matrix snapshots, and emits a 4-bit key code plus a one-cycle press event. It sits between the JA connector pins and the character-control logic, in the clk domain.

## Interface

- SCAN_DIV, 100000: clk cycles each column is held low (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix snapshots required to accept a new state; range 1..15.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- row  in  4  keypad row returns, active-low, asynchronous to clk.
- col  out  4  column strobes, one-cold, active-low.
- key_code  out  4  hex code of the current or last accepted key.
- key_valid  out  1  one-cycle pulse when a new key is accepted.
- key_held  out  1  high while the debounced state has at least one key pressed.

## Operation

- Column index c = 0..3 drives col = 0111, 1011, 1101, 1110 respectively. Each column is held for SCAN_DIV cycles, then the scanner advances c, wrapping 3 -> 0.
- Key map, with row[r] low while column c is active (r = 0 is the top row):
  - c0: 1, 4, 7, 0
  - c1: 2, 5, 8, F
  - c2: 3, 6, 9, E
  - c3: A, B, C, D
- row passes through a 2-flop synchronizer before use.
- The synchronized row is sampled on the last cycle of each column dwell. The sampled value, inverted (pressed = 1), is stored into snapshot bits [4c+3:4c].
- A snapshot is complete at the end of the c3 dwell. At that point:
  - If it equals the previous snapshot, stable_cnt increments, saturating. Otherwise stable_cnt clears to 0.
  - When the snapshot has matched for DEBOUNCE_SCANS consecutive snapshots, it is copied to the debounced state. With DEBOUNCE_SCANS = 1, every snapshot is accepted.
- Priority: if several keys are pressed, the selected key is the one with the lowest index 4c+r.
- key_valid pulses when the debounced state is updated and either:
  - the selected key differs from the previous selected key, or
  - the previous debounced state was empty.
  Rolling from key X to key Y without a release therefore pulses for Y.
- key_code updates in the same cycle as the pulse. It retains its value after release.
- key_held = OR of the debounced state.
- Reset mid-scan: all state returns to its reset value immediately. Scanning restarts at c0 with a fresh dwell count.

## Timing

- Reset values: col = 0111, key_code = 0, key_valid = 0, key_held = 0. Dwell counter, c, snapshot, previous snapshot, debounced state and stable_cnt are all 0.
- Scan period is 4*SCAN_DIV cycles. The first column advance happens SCAN_DIV cycles after rst deasserts.
- key_valid and key_code are registered and assert 1 cycle after the snapshot-completion cycle. key_held changes in that same cycle.
- Worst-case press latency, from a stable row change to key_valid: (DEBOUNCE_SCANS + 1) * 4*SCAN_DIV + 3 cycles, which includes the synchronizer.
- key_valid is never high for two consecutive cycles.
- col changes only on dwell boundaries and is always exactly one-cold.

## Test plan

Benches use SCAN_DIV = 4 and DEBOUNCE_SCANS = 2, so the scan period is 16 cycles.

- Reset and free-run: hold rst low, then release. col = 0111 for cycles 1-4, 1011 for cycles 5-8, then 1101, then 1110, wrapping. key_valid and key_held stay 0 with row = 1111.
- Single press: model the matrix so key 5 (c1, r1) pulls row[1] low while col = 1011. Exactly one key_valid pulse occurs, with key_code = 5 and key_held = 1, within 3 scans + 3 cycles. On release, key_held drops after 2 matching empty snapshots and key_code stays 5.
- Bounce rejection: toggle key 9 every other scan for 6 scans, then hold it. No key_valid during the toggling. After holding, one pulse with key_code = 9.
- Simultaneous keys: hold 0 (c0, r3) and A (c3, r0). key_code = 0, from index 3 versus 12. Then release 0 while A stays held: a second pulse with key_code = A.
- Reset mid-operation: assert rst while key_held = 1 and col = 1101. All outputs are at reset values within the same cycle. After release, a still-held key produces a fresh key_valid.
- Roll-over: press 1, then press 2 before releasing 1, then release 1. Pulses occur for 1 and then for 2, and key_held never drops.
